niosqs_pio_in: RTL
==================

// Module: niosqs_pio_in
// PURPOSE
// - Avalon-MM slave input PIO; read-side counterpart of the system's 8-bit output PIO.
// - Samples external pins (LCD busy/status, push-buttons) into the NIOS clock domain.
// - Latches per-bit edge events and raises a maskable level interrupt to the CPU.
// - Sits on the same Avalon bus segment and register map style as the output PIO.
// PARAMETERS
// - WIDTH      8  number of input pins; bit-widths of all data registers
// - EDGE_TYPE  0  capture edge: 0 rising, 1 falling, 2 any
// PORTS
// - clk         in   1      system clock; all logic on rising edge
// - reset       in   1      synchronous, active-high reset
// - address     in   2      register select: 0 DATA, 2 IRQMASK, 3 EDGECAP; 1 reserved
// - chipselect  in   1      slave select
// - read        in   1      read strobe, qualified by chipselect
// - write_n     in   1      active-low write strobe, qualified by chipselect
// - writedata   in   32     write data; bits [WIDTH-1:0] used
// - in_port     in   WIDTH  asynchronous external inputs
// - readdata    out  32     read data, zero-extended above WIDTH
// - irq         out  1      level interrupt to CPU
// BEHAVIOUR
// - Reset (reset=1 at clk edge): sync1, sync2, prev, edgecap, irqmask, readdata <= 0; prime_cnt <= 0.
// - Synchroniser: sync1 <= in_port; sync2 <= sync1; prev <= sync2. Two-flop; no logic between stages.
// - Edge detect, per bit: rise = sync2 & ~prev; fall = ~sync2 & prev; any = sync2 ^ prev; selected by EDGE_TYPE.
// - Priming: 2-bit prime_cnt increments after reset, saturating at 3.
//   - Edge capture enabled only while prime_cnt == 3 (registered value).
//   - Effect: no spurious capture from the post-reset pipeline fill; earliest capture is the 4th edge after reset release.
// - Latency: in_port changes before clk edge E0; sync1 updates at E0, sync2 at E1.
//   - edgecap bit sets at E2; irq valid after E2.
//   - A DATA read issued after E1 reflects the new value.
// - Reads: 1-cycle read latency. On chipselect & read at edge E, readdata is loaded at E:
//   - addr 0 -> sync2
//   - addr 2 -> irqmask
//   - addr 3 -> edgecap
//   - addr 1 -> 0
//   - readdata holds its value until the next read. Reads have no side effects.
// - Writes: chipselect & ~write_n.
//   - addr 2: irqmask <= writedata[WIDTH-1:0].
//   - addr 3: write-1-to-clear, edgecap <= (edgecap & ~wd) | new_edges.
//   - addr 0 and addr 1: ignored.
// - Simultaneous edge and clear on the same bit, same cycle: set wins; bit stays 1.
// - Simultaneous read and write to the same register: read returns the pre-write value.
// - irq = |(edgecap & irqmask), combinational from registers.
//   - Unmasking a bit with pending edgecap asserts irq in the following cycle.
// - Reset mid-operation: all state, including pending edgecap and irq, clears at the next clk edge; priming restarts.
// - No FSM beyond prime_cnt. Bits above WIDTH in writedata are ignored.
// STRUCTURE
// - Shared package niosqs_pio_pkg:
//   - register address constants (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3)
//   - EDGE_TYPE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY)
// - One sub-module: niosqs_sync2, a parameterised-width two-flop synchroniser, reused by other pin inputs.
// - Edge logic, registers and read mux stay in this module.
// TESTING
// - Reset with in_port=8'hFF held, 10 cycles -> edgecap==0, irq==0, DATA read returns 32'h000000FF.
// - EDGE_TYPE=0, irqmask=8'h01, in_port 0->1 on bit0 -> edgecap[0]=1 at E2, irq=1.
//   - Then write 8'h01 to addr 3 -> edgecap==0, irq deasserts the next cycle.
// - Write-1-to-clear to addr 3 in the same cycle a new rising edge arrives on bit0 -> edgecap[0] stays 1.
// - irqmask=0, bit3 edge captured -> irq=0; then write irqmask=8'h08 -> irq=1 the next cycle; readback of addr 2 is 32'h8.
// - EDGE_TYPE=2, bit5 toggled 1->0->1 spaced 4 cycles apart -> edgecap[5] set after each toggle (clear between toggles to observe both).
//   - A 1-cycle glitch shorter than the sync path is still captured once.
// - Assert reset while edgecap=8'hA5 and irq=1 -> next edge edgecap==0, irq==0, readdata==0; addr 1 read returns 0.

Source files
------------

// File: rtl/niosqs_pio_pkg.sv
// ---------------------------------------------------------------------------
// niosqs_pio_pkg
// Shared definitions for the NIOS PIO blocks (input and output PIO):
//   - Avalon register addresses used by the PIO register map
//   - capture-edge encodings for the input PIO EDGE_TYPE parameter
//   - per-bit edge-select helper used by the input PIO edge detector
// ---------------------------------------------------------------------------
package niosqs_pio_pkg;

    // Register map (word addresses on the 2-bit Avalon address bus).
    // Address 1 is reserved and reads back as zero.
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Capture-edge encodings for EDGE_TYPE.
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Priming counter saturates here; capture is enabled only at this value.
    localparam logic [1:0] PRIME_DONE = 2'd3;

    // Edge event for one bit, given the current and previous synchronised
    // samples. Unknown encodings fall back to rising-edge capture.
    function automatic logic edge_sel(input int edge_type, input logic cur, input logic prv);
        case (edge_type)
            EDGE_FALL: return ~cur & prv;
            EDGE_ANY:  return cur ^ prv;
            default:   return cur & ~prv;
        endcase
    endfunction

endpackage

// File: rtl/niosqs_sync2.sv
// ---------------------------------------------------------------------------
// niosqs_sync2
// Parameterised-width two-flop synchroniser for asynchronous pin inputs.
// No logic between the stages so the first flop has a full cycle to settle.
// Ports:
//   clk    in   1      system clock
//   reset  in   1      synchronous, active-high reset (clears both stages)
//   d      in   WIDTH  asynchronous input
//   q      out  WIDTH  synchronised output (two clk edges after d)
// ---------------------------------------------------------------------------
module niosqs_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/niosqs_pio_in.sv
// ---------------------------------------------------------------------------
// niosqs_pio_in
// Avalon-MM slave input PIO. Synchronises external pins (LCD status,
// push-buttons) into the clk domain, latches per-bit edge events in EDGECAP
// and raises a maskable level interrupt.
//
// Register map:
//   0 DATA     (RO) synchronised pin value
//   1 reserved (reads 0, writes ignored)
//   2 IRQMASK  (RW) per-bit interrupt enable
//   3 EDGECAP  (RW1C) latched edge events
//
// Bus semantics: a read is chipselect & read at a clk edge; readdata is
// loaded at that same edge (one-cycle latency) and holds until the next
// read. A write is chipselect & ~write_n at a clk edge. There is no
// waitrequest: every access completes in the cycle it is presented. Reads
// have no side effects; a read and write of the same register in one cycle
// returns the pre-write value.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   reset       in   1      synchronous, active-high reset
//   address     in   2      register select
//   chipselect  in   1      slave select
//   read        in   1      read strobe
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data, bits [WIDTH-1:0] used
//   in_port     in   WIDTH  asynchronous external inputs
//   readdata    out  32     read data, zero-extended above WIDTH
//   irq         out  1      level interrupt, |(edgecap & irqmask)
//
// WIDTH must be in 1..32.
// ---------------------------------------------------------------------------
module niosqs_pio_in
    import niosqs_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] irqmask;
    logic [1:0]       prime_cnt;

    logic             rd_en;
    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] new_edges;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] edgecap_next;
    logic [31:0]      rd_mux;

    // Upper writedata bits are don't-care for this block.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    niosqs_sync2 #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (sync2)
    );

    assign rd_en = chipselect & read;
    assign wr_en = chipselect & ~write_n;
    assign wd    = writedata[WIDTH-1:0];

    // Edge detection. Capture is held off until the priming counter has
    // saturated: by then prev has been loaded from a valid sync2, so the
    // pipeline fill after reset cannot look like an edge.
    always_comb begin
        new_edges = '0;
        if (prime_cnt == PRIME_DONE) begin
            for (int i = 0; i < WIDTH; i++) begin
                new_edges[i] = edge_sel(EDGE_TYPE, sync2[i], prev[i]);
            end
        end
    end

    // Write-1-to-clear, with a fresh edge on the same bit winning over the
    // clear so no event is lost.
    always_comb begin
        clr_mask = '0;
        if (wr_en && address == ADDR_EDGECAP) begin
            clr_mask = wd;
        end
        edgecap_next = (edgecap & ~clr_mask) | new_edges;
    end

    // Read mux samples register values before this cycle's updates, which
    // gives read-before-write behaviour on a simultaneous access.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux = 32'(sync2);
            ADDR_IRQMASK: rd_mux = 32'(irqmask);
            ADDR_EDGECAP: rd_mux = 32'(edgecap);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev      <= '0;
            edgecap   <= '0;
            irqmask   <= '0;
            readdata  <= '0;
            prime_cnt <= '0;
        end else begin
            prev    <= sync2;
            edgecap <= edgecap_next;
            if (prime_cnt != PRIME_DONE) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= wd;
            end
            if (rd_en) begin
                readdata <= rd_mux;
            end
        end
    end

    assign irq = |(edgecap & irqmask);

endmodule
